// File: rtl/rvv_cfg_pkg.sv
// Shared types and constants for the vector-configuration (vset*) unit.
// Holds the SEW / LMUL encodings, the request-kind and FSM-state enums, the
// vtype field positions, and a helper that reduces a (vsew, vlmul) pair to
// log2(SEW/LMUL).
package rvv_cfg_pkg;

  typedef enum logic [2:0] {
    SEW8  = 3'b000,
    SEW16 = 3'b001,
    SEW32 = 3'b010,
    SEW64 = 3'b011
  } sew_e;

  typedef enum logic [2:0] {
    LMUL1     = 3'b000,
    LMUL2     = 3'b001,
    LMUL4     = 3'b010,
    LMUL8     = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL1_8   = 3'b101,
    LMUL1_4   = 3'b110,
    LMUL1_2   = 3'b111
  } lmul_e;

  typedef enum logic [1:0] {
    KIND_VSETVLI  = 2'd0,
    KIND_VSETIVLI = 2'd1,
    KIND_VSETVL   = 2'd2,
    KIND_ILLEGAL  = 2'd3
  } cfg_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CALC,
    ST_RESP
  } vcfg_state_e;

  // vtype field positions; bits [XLEN-2:VTYPE_RSVD_LSB] are reserved,
  // bit XLEN-1 is vill.
  localparam int VTYPE_VLMUL_LSB = 0;
  localparam int VTYPE_VSEW_LSB  = 3;
  localparam int VTYPE_VTA_BIT   = 6;
  localparam int VTYPE_VMA_BIT   = 7;
  localparam int VTYPE_RSVD_LSB  = 8;

  // Signed log2 of LMUL; the reserved encoding maps to 0 and is flagged
  // as illegal elsewhere.
  function automatic int lmul_log2(input logic [2:0] vlmul);
    case (lmul_e'(vlmul))
      LMUL1:   return 0;
      LMUL2:   return 1;
      LMUL4:   return 2;
      LMUL8:   return 3;
      LMUL1_8: return -3;
      LMUL1_4: return -2;
      LMUL1_2: return -1;
      default: return 0;
    endcase
  endfunction

  // log2(SEW/LMUL) up to a constant offset; equal values mean equal VLMAX.
  function automatic int ratio_log2(input logic [2:0] vsew, input logic [2:0] vlmul);
    return int'(vsew) - lmul_log2(vlmul);
  endfunction

endpackage

// File: rtl/rvv_vlmax_calc.sv
// Combinational VLMAX calculator.
// VLMAX = (VLEN/SEW)*LMUL, computed as a single power of two.
// Ports:
//   vsew    [2:0]           vtype.vsew encoding
//   vlmul   [2:0]           vtype.vlmul encoding
//   vlmax   [log2(VLEN):0]  elements per register group (0 when illegal)
//   illegal                 unsupported SEW / LMUL combination
module rvv_vlmax_calc
  import rvv_cfg_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic [2:0]           vsew,
  input  logic [2:0]           vlmul,
  output logic [$clog2(VLEN):0] vlmax,
  output logic                 illegal
);

  localparam int VLEN_LOG = $clog2(VLEN);
  localparam int ELEN_LOG = $clog2(ELEN);
  localparam logic [VLEN_LOG:0] VLMAX_ONE = 1;

  int sew_log;
  int lmul_log;
  int vlmax_log;

  // NOTE: every signal written here gets a value before any branch, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sew_log   = int'(vsew) + 3;
    lmul_log  = lmul_log2(vlmul);
    vlmax_log = VLEN_LOG - sew_log + lmul_log;
    illegal   = 1'b0;
    vlmax     = '0;

    // Reserved vsew encodings (>= 4) also land here since sew_log > 6.
    if (sew_log > ELEN_LOG) illegal = 1'b1;
    if (vlmul == LMUL_RSVD) illegal = 1'b1;
    // Fractional LMUL: SEW must fit in ELEN*LMUL.
    if (lmul_log < 0 && sew_log > ELEN_LOG + lmul_log) illegal = 1'b1;

    if (!illegal) vlmax = VLMAX_ONE << vlmax_log;
  end

endmodule

// File: rtl/rvv_vcfg_unit.sv
// Vector configuration unit executing vsetvli / vsetivli / vsetvl.
// A request is accepted in IDLE, waits in DRAIN for older vector uops,
// computes vl/vtype in CALC, and offers the result in RESP. The committed
// vl/vtype CSRs change only when the response handshake completes.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cfg_valid/cfg_ready          request handshake
//   cfg_kind, cfg_avl, cfg_vtype request fields; cfg_rs1_x0/cfg_rd_x0 flag x0 operands
//   drain_busy                   older vector uops still in flight
//   flush                        abort any pending request
//   resp_valid/resp_ready        response handshake
//   resp_rd_data, resp_rd_we     new vl and rd write enable
//   arch_vl, arch_vtype          committed CSR state
module rvv_vcfg_unit
  import rvv_cfg_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int XLEN = 32,
  parameter int ELEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [1:0]      cfg_kind,
  input  logic [XLEN-1:0] cfg_avl,
  input  logic [XLEN-1:0] cfg_vtype,
  input  logic            cfg_rs1_x0,
  input  logic            cfg_rd_x0,
  input  logic            drain_busy,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rd_data,
  output logic            resp_rd_we,
  output logic [XLEN-1:0] arch_vl,
  output logic [XLEN-1:0] arch_vtype
);

  localparam logic [XLEN-1:0] VTYPE_VILL = {1'b1, {(XLEN-1){1'b0}}};

  vcfg_state_e state_q, state_d;
  logic        accept, commit;

  // Captured request
  cfg_kind_e       kind_q;
  logic [XLEN-1:0] avl_q;
  logic [XLEN-2:0] vtype_q;
  logic            rs1_x0_q, rd_x0_q;

  // Computed result and committed state
  logic [XLEN-1:0] vl_q, new_vtype_q, arch_vl_q, arch_vtype_q;
  logic            rd_we_q;

  // The requested vill bit is never copied; vill is recomputed from scratch.
  logic unused_vill_src;
  assign unused_vill_src = cfg_vtype[XLEN-1];

  logic [$clog2(VLEN):0] vlmax;
  logic                  cfg_illegal;

  rvv_vlmax_calc #(.VLEN(VLEN), .ELEN(ELEN)) u_vlmax (
    .vsew   (vtype_q[VTYPE_VSEW_LSB +: 3]),
    .vlmul  (vtype_q[VTYPE_VLMUL_LSB +: 3]),
    .vlmax  (vlmax),
    .illegal(cfg_illegal)
  );

  always_comb begin
    state_d    = state_q;
    cfg_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && !flush) begin
          accept  = 1'b1;
          state_d = drain_busy ? ST_DRAIN : ST_CALC;
        end
      end
      ST_DRAIN: begin
        if (flush)            state_d = ST_IDLE;
        else if (!drain_busy) state_d = ST_CALC;
      end
      ST_CALC: begin
        state_d = flush ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        // Flush wins over a completing handshake: nothing is committed.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (resp_ready) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // vl / vtype computation from the captured request.
  logic [XLEN-1:0] avl_sel, vlmax_x, vl_calc, vtype_calc;
  logic            keep_vl, ratio_change, vill;

  always_comb begin
    keep_vl = (kind_q != KIND_VSETIVLI) && rs1_x0_q && rd_x0_q;
    if (kind_q == KIND_VSETIVLI || !rs1_x0_q) avl_sel = avl_q;
    else if (!rd_x0_q)                        avl_sel = '1;
    else                                      avl_sel = arch_vl_q;

    // Keeping vl is only meaningful if VLMAX is unchanged, i.e. the
    // SEW/LMUL ratio matches a valid committed vtype.
    ratio_change = keep_vl &&
                   (arch_vtype_q[XLEN-1] ||
                    ratio_log2(vtype_q[VTYPE_VSEW_LSB +: 3], vtype_q[VTYPE_VLMUL_LSB +: 3]) !=
                    ratio_log2(arch_vtype_q[VTYPE_VSEW_LSB +: 3], arch_vtype_q[VTYPE_VLMUL_LSB +: 3]));

    vill = cfg_illegal || (kind_q == KIND_ILLEGAL) ||
           (|vtype_q[XLEN-2:VTYPE_RSVD_LSB]) || ratio_change;

    vlmax_x    = XLEN'(vlmax);
    vl_calc    = (avl_sel < vlmax_x) ? avl_sel : vlmax_x;
    vtype_calc = {{(XLEN-VTYPE_RSVD_LSB){1'b0}}, vtype_q[VTYPE_RSVD_LSB-1:0]};
    if (vill) begin
      vl_calc    = '0;
      vtype_calc = VTYPE_VILL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vl_q         <= '0;
      rd_we_q      <= 1'b0;
      new_vtype_q  <= VTYPE_VILL;
      arch_vl_q    <= '0;
      arch_vtype_q <= VTYPE_VILL;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CALC && !flush) begin
        vl_q        <= vl_calc;
        rd_we_q     <= !rd_x0_q;
        new_vtype_q <= vtype_calc;
      end
      if (commit) begin
        arch_vl_q    <= vl_q;
        arch_vtype_q <= new_vtype_q;
      end
    end
  end

  // NOTE: the request capture registers carry no reset; they are only read
  // after an accept has loaded them, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      kind_q   <= cfg_kind_e'(cfg_kind);
      avl_q    <= cfg_avl;
      vtype_q  <= cfg_vtype[XLEN-2:0];
      rs1_x0_q <= cfg_rs1_x0;
      rd_x0_q  <= cfg_rd_x0;
    end
  end

  assign resp_rd_data = vl_q;
  assign resp_rd_we   = rd_we_q;
  assign arch_vl      = arch_vl_q;
  assign arch_vtype   = arch_vtype_q;

endmodule

// File: tb/tb_rvv_vcfg_unit.sv
// Self-checking bench for rvv_vcfg_unit (VLEN=128, XLEN=32, ELEN=32).
// A vector table covers the vl/vtype function; hand sequences cover drain,
// backpressure, flush and reset. Expected responses are queued on accept
// and compared by a monitor at the response handshake.
module tb_rvv_vcfg_unit;
  import rvv_cfg_pkg::*;

  localparam logic [31:0] VILL = 32'h8000_0000;

  logic        clk, rst;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_kind;
  logic [31:0] cfg_avl, cfg_vtype;
  logic        cfg_rs1_x0, cfg_rd_x0;
  logic        drain_busy, flush;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rd_data;
  logic        resp_rd_we;
  logic [31:0] arch_vl, arch_vtype;

  rvv_vcfg_unit #(.VLEN(128), .XLEN(32), .ELEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_kind    (cfg_kind),
    .cfg_avl     (cfg_avl),
    .cfg_vtype   (cfg_vtype),
    .cfg_rs1_x0  (cfg_rs1_x0),
    .cfg_rd_x0   (cfg_rd_x0),
    .drain_busy  (drain_busy),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rd_data(resp_rd_data),
    .resp_rd_we  (resp_rd_we),
    .arch_vl     (arch_vl),
    .arch_vtype  (arch_vtype)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] avl;
    logic [31:0] vtype;
    logic        rs1_x0;
    logic        rd_x0;
    logic [31:0] exp_vl;
    logic        exp_we;
    logic [31:0] exp_vtype;
  } vec_t;

  typedef struct packed {
    logic [31:0] vl;
    logic        we;
    logic [31:0] vtype;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t arch_exp;
  bit   arch_pending = 0;
  logic [31:0] last_vl = 32'd0;
  logic [31:0] last_vtype = VILL;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: compare at the handshake, then check the committed
  // CSRs one cycle later.
  always @(negedge clk) begin
    if (arch_pending) begin
      check("arch_vl_commit", arch_vl, arch_exp.vl);
      check("arch_vtype_commit", arch_vtype, arch_exp.vtype);
      arch_pending = 0;
    end
    if (!rst && !flush && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got response vl=0x%08h, expected none", resp_rd_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rd_data", resp_rd_data, e.vl);
        check("resp_rd_we", {31'd0, resp_rd_we}, {31'd0, e.we});
        arch_exp     = e;
        arch_pending = 1;
        last_vl      = e.vl;
        last_vtype   = e.vtype;
      end
    end
  end

  task automatic send(input vec_t v, input bit expect_resp);
    int n = 0;
    cfg_kind   = v.kind;
    cfg_avl    = v.avl;
    cfg_vtype  = v.vtype;
    cfg_rs1_x0 = v.rs1_x0;
    cfg_rd_x0  = v.rd_x0;
    cfg_valid  = 1'b1;
    while (!cfg_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cfg_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: cfg_ready got 0, expected 1 within 100 cycles");
      cfg_valid = 1'b0;
      return;
    end
    if (expect_resp) sb.push_back('{v.exp_vl, v.exp_we, v.exp_vtype});
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !cfg_ready) && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (sb.size() != 0 || !cfg_ready) begin
      n_bad++;
      $display("FAIL wait_idle: got %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  vec_t vecs [18];
  vec_t v;

  initial begin
    // kind, avl, vtype, rs1_x0, rd_x0, exp_vl, exp_we, exp_vtype
    vecs[0]  = '{2'd0, 32'd20,  32'h000, 1'b0, 1'b0, 32'd16,  1'b1, 32'h000}; // SEW8 LMUL1
    vecs[1]  = '{2'd1, 32'd3,   32'h015, 1'b0, 1'b0, 32'd0,   1'b1, VILL};    // SEW32 LMUL1/8
    vecs[2]  = '{2'd2, 32'd0,   32'h013, 1'b1, 1'b0, 32'd32,  1'b1, 32'h013}; // x0 avl, SEW32 LMUL8
    vecs[3]  = '{2'd2, 32'd0,   32'h00A, 1'b1, 1'b1, 32'd32,  1'b0, 32'h00A}; // keep vl, same ratio
    vecs[4]  = '{2'd2, 32'd0,   32'h002, 1'b1, 1'b1, 32'd0,   1'b0, VILL};    // keep vl, ratio change
    vecs[5]  = '{2'd0, 32'd5,   32'h0C9, 1'b0, 1'b0, 32'd5,   1'b1, 32'h0C9}; // SEW16 LMUL2 ta/ma
    vecs[6]  = '{2'd0, 32'd100, 32'h007, 1'b0, 1'b0, 32'd8,   1'b1, 32'h007}; // SEW8 LMUL1/2
    vecs[7]  = '{2'd0, 32'd10,  32'h00E, 1'b0, 1'b0, 32'd0,   1'b1, VILL};    // SEW16 LMUL1/4
    vecs[8]  = '{2'd0, 32'd10,  32'h018, 1'b0, 1'b0, 32'd0,   1'b1, VILL};    // SEW64 > ELEN
    vecs[9]  = '{2'd0, 32'd10,  32'h004, 1'b0, 1'b0, 32'd0,   1'b1, VILL};    // reserved vlmul
    vecs[10] = '{2'd0, 32'd10,  32'h100, 1'b0, 1'b0, 32'd0,   1'b1, VILL};    // reserved bit 8
    vecs[11] = '{2'd3, 32'd4,   32'h000, 1'b0, 1'b0, 32'd0,   1'b1, VILL};    // illegal kind
    vecs[12] = '{2'd2, 32'd0,   32'h000, 1'b1, 1'b1, 32'd0,   1'b0, VILL};    // keep vl from vill
    vecs[13] = '{2'd1, 32'd7,   32'h000, 1'b1, 1'b1, 32'd7,   1'b0, 32'h000}; // ivli ignores x0 flags
    vecs[14] = '{2'd0, 32'd0,   32'h000, 1'b0, 1'b0, 32'd0,   1'b1, 32'h000}; // avl 0
    vecs[15] = '{2'd2, 32'd0,   32'h003, 1'b1, 1'b0, 32'd128, 1'b1, 32'h003}; // VLMAX 128
    vecs[16] = '{2'd0, 32'd4,   32'h010, 1'b0, 1'b0, 32'd4,   1'b1, 32'h010}; // avl == VLMAX
    vecs[17] = '{2'd0, 32'd17,  32'h000, 1'b0, 1'b0, 32'd16,  1'b1, 32'h000}; // avl == VLMAX+1

    rst = 1'b1; cfg_valid = 1'b0; cfg_kind = 2'd0; cfg_avl = '0; cfg_vtype = '0;
    cfg_rs1_x0 = 1'b0; cfg_rd_x0 = 1'b0; drain_busy = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rd_we", {31'd0, resp_rd_we}, 32'd0);
    check("rst_resp_rd_data", resp_rd_data, 32'd0);
    check("rst_arch_vl", arch_vl, 32'd0);
    check("rst_arch_vtype", arch_vtype, VILL);

    for (int i = 0; i < 18; i++) send(vecs[i], 1'b1);
    wait_idle();

    // Drain for 5 cycles, then 3 cycles of response backpressure.
    v = '{2'd0, 32'd9, 32'h000, 1'b0, 1'b0, 32'd9, 1'b1, 32'h000};
    resp_ready = 1'b0;
    drain_busy = 1'b1;
    send(v, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("drain_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("drain_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      tick();
    end
    drain_busy = 1'b0;
    tick();
    check("drain_lat_1", {31'd0, resp_valid}, 32'd0);
    tick();
    check("drain_lat_2", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_resp_rd_data", resp_rd_data, 32'd9);
      check("bp_arch_vl", arch_vl, last_vl);
      tick();
    end
    resp_ready = 1'b1;
    wait_idle();

    // Minimum latency without drain: resp_valid two cycles after accept.
    v = '{2'd0, 32'd2, 32'h000, 1'b0, 1'b0, 32'd2, 1'b1, 32'h000};
    resp_ready = 1'b0;
    send(v, 1'b1);
    check("lat_calc", {31'd0, resp_valid}, 32'd0);
    tick();
    check("lat_resp", {31'd0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    wait_idle();

    // Flush in CALC.
    v = '{2'd0, 32'd3, 32'h000, 1'b0, 1'b0, 32'd3, 1'b1, 32'h000};
    send(v, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_calc_ready", {31'd0, cfg_ready}, 32'd1);
    check("flush_calc_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    check("flush_calc_valid2", {31'd0, resp_valid}, 32'd0);
    check("flush_calc_arch_vl", arch_vl, last_vl);

    // Flush coincident with a completing response handshake.
    v = '{2'd0, 32'd6, 32'h000, 1'b0, 1'b0, 32'd6, 1'b1, 32'h000};
    resp_ready = 1'b0;
    send(v, 1'b0);
    tick();
    check("flush_resp_valid", {31'd0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_resp_gone", {31'd0, resp_valid}, 32'd0);
    tick();
    check("flush_resp_arch_vl", arch_vl, last_vl);
    check("flush_resp_arch_vtype", arch_vtype, last_vtype);

    // Flush in IDLE blocks acceptance.
    cfg_kind = 2'd0; cfg_avl = 32'd5; cfg_vtype = 32'h0; cfg_rs1_x0 = 1'b0; cfg_rd_x0 = 1'b0;
    cfg_valid = 1'b1;
    flush = 1'b1;
    tick();
    cfg_valid = 1'b0;
    flush = 1'b0;
    check("idle_flush_ready", {31'd0, cfg_ready}, 32'd1);
    tick(); tick();
    check("idle_flush_no_resp", {31'd0, resp_valid}, 32'd0);

    // Reset in the middle of DRAIN.
    v = '{2'd0, 32'd11, 32'h000, 1'b0, 1'b0, 32'd11, 1'b1, 32'h000};
    drain_busy = 1'b1;
    send(v, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drain_busy = 1'b0;
    last_vl = 32'd0;
    last_vtype = VILL;
    check("mid_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("mid_rst_arch_vl", arch_vl, 32'd0);
    check("mid_rst_arch_vtype", arch_vtype, VILL);
    check("mid_rst_rd_data", resp_rd_data, 32'd0);
    check("mid_rst_rd_we", {31'd0, resp_rd_we}, 32'd0);
    tick(); tick();
    check("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);

    // Normal operation resumes after reset.
    send(vecs[0], 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got stuck, expected to reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rvv_vcfg_unit.md
RVV_VCFG_UNIT -- requirements
Module: rvv_vcfg_unit

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits (power of two, 64..1024).
REQ-002 SHALL have parameter XLEN, default 32, scalar operand and result width.
REQ-003 SHALL have parameter ELEN, default 32, maximum legal SEW (32 or 64).
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset: one clock, synchronous, active-high.
REQ-006 SHALL have ports cfg_valid input 1 and cfg_ready output 1, request handshake; transfer when both are high.
REQ-007 SHALL have cfg_kind input 2: VSETVLI=0, VSETIVLI=1, VSETVL=2; value 3 is illegal.
REQ-008 SHALL have cfg_avl input XLEN (rs1 value or zero-extended uimm5), cfg_vtype input XLEN, cfg_rs1_x0 input 1, cfg_rd_x0 input 1.
REQ-009 SHALL have drain_busy input 1, high while older vector uops are still in flight.
REQ-010 SHALL have flush input 1, abort of any pending request.
REQ-011 SHALL have resp_valid output 1 and resp_ready input 1, response handshake.
REQ-012 SHALL have resp_rd_data output XLEN (new vl) and resp_rd_we output 1 (high when rd is not x0).
REQ-013 SHALL have arch_vl output XLEN and arch_vtype output XLEN, the committed CSR state.

Function
REQ-014 SHALL implement FSM IDLE->DRAIN->CALC->RESP->IDLE; cfg_ready is high only in IDLE.
REQ-015 On accept, SHALL capture all cfg_* fields; go to DRAIN if drain_busy is high, else to CALC.
REQ-016 In DRAIN SHALL hold until drain_busy is low, then go to CALC.
REQ-017 In CALC SHALL compute VLMAX = (VLEN/SEW)*LMUL (fractional LMUL 1/2, 1/4, 1/8), register the result, and go to RESP; minimum accept-to-resp_valid latency is 2 cycles.
REQ-018 vill SHALL be set when any of these hold: vsew>ELEN; vlmul==3'b100; SEW > ELEN*LMUL for fractional LMUL; vtype bits [XLEN-2:8] nonzero; cfg_kind==3.
REQ-019 AVL selection: if cfg_rs1_x0=0 or kind=VSETIVLI, use cfg_avl; if rs1=x0 and rd!=x0, use all-ones; if rs1=x0 and rd=x0, keep the current arch_vl.
REQ-020 In the keep-vl case, if the new SEW/LMUL ratio differs from the committed ratio, SHALL set vill.
REQ-021 vl = min(AVL, VLMAX); on vill, vl=0 and vtype = {1'b1, zeros}.
REQ-022 arch_vl and arch_vtype SHALL update in the same cycle the response handshake completes, not before.
REQ-023 In RESP, SHALL hold resp_valid and resp_* stable until resp_ready; back-to-back accept is allowed in the cycle after handshake (IDLE).
REQ-024 flush in DRAIN, CALC, or RESP SHALL return the FSM to IDLE next cycle with no arch update and resp_valid low; flush coincident with a completing resp handshake SHALL take priority (no commit).
REQ-025 flush in IDLE coincident with cfg_valid SHALL cause the request not to be accepted.

Reset
REQ-026 rst SHALL force state IDLE, resp_valid=0, resp_rd_we=0, resp_rd_data=0, arch_vl=0, arch_vtype={1'b1, zeros} (vill), and cfg_ready=1 in the cycle after release.
REQ-027 rst asserted mid-request SHALL discard the request with no arch update.

Structure
REQ-028 Shared package rvv_cfg_pkg SHALL hold: sew_e extended with SEW64=3'b011; lmul_e extended with LMUL1_8=3'b101; cfg_kind_e; vcfg_state_e; vtype field-position constants.
REQ-029 SHALL contain one combinational sub-module, rvv_vlmax_calc (inputs vsew, vlmul; outputs vlmax, illegal), parametrised by VLEN and ELEN.

Verification (VLEN=128, XLEN=32, ELEN=32)
REQ-030 vsetvli avl=20, SEW8, LMUL1, rd!=x0 -> resp_rd_data=16, arch_vl=16, vtype=0x000 after handshake.
REQ-031 vsetivli uimm=3, SEW32, LMUL1_8 -> vill: resp_rd_data=0, arch_vtype=0x80000000.
REQ-032 vsetvl rs1=x0, rd!=x0, SEW32, LMUL8 -> vl=32; then rs1=x0, rd=x0, SEW16, LMUL4 (same ratio) -> vl stays 32; then SEW8, LMUL4 (ratio change) -> vill.
REQ-033 drain_busy high for 5 cycles after accept -> resp_valid rises exactly 2 cycles after drain_busy falls; resp_ready held low 3 cycles -> outputs stable, arch unchanged until handshake.
REQ-034 flush in CALC -> no resp_valid, arch_vl unchanged, cfg_ready high next cycle; rst mid-DRAIN -> arch_vl=0, arch_vtype=0x80000000.
